// File: rtl/link_parameter_loader.sv
// Streams per-link {weight, boundary} entries into the parallel parameter buses of a link row.
// Optional entry sanitising/error flag is enabled by defining LINK_LOADER_PARAM_CHECK_EN.
module link_parameter_loader #(
  parameter int NUM_LINKS      = 8,
  parameter int MAX_WEIGHT     = 2,
  parameter int STAGE_WIDTH    = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = STAGE_WIDTH'(1),
  parameter int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [STAGE_WIDTH-1:0]             global_stage,
  input  logic                               param_valid,
  input  logic [LINK_BIT_WIDTH-1:0]          param_weight,
  input  logic [1:0]                         param_boundary,
  output logic                               param_ready,
  output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_bus,
  output logic [NUM_LINKS*2-1:0]             boundary_bus,
  output logic                               loaded,
  output logic                               param_error
);

  localparam int IDX_WIDTH = (NUM_LINKS > 2) ? $clog2(NUM_LINKS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_LINKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_reg, state_next;
  logic [IDX_WIDTH-1:0]      idx_reg, idx_next;
  logic                      loaded_reg, loaded_next;
  logic                      stage_match;
  logic                      accept;
  logic                      load_entry;
  logic [LINK_BIT_WIDTH-1:0] wr_weight;
  logic [1:0]                wr_boundary;

  assign stage_match = (global_stage == STAGE_PARAMETERS_LOADING);
  // Ready depends only on the state register, never on param_valid.
  assign param_ready = (state_reg == LOAD);
  assign accept      = param_valid & param_ready;
  assign load_entry  = (state_reg == IDLE) & stage_match;
  assign loaded      = loaded_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      loaded_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      loaded_reg <= loaded_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    loaded_next = loaded_reg;
    case (state_reg)
      IDLE: begin
        if (stage_match) begin
          state_next  = LOAD;
          idx_next    = '0;
          loaded_next = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (idx_reg == LAST_IDX) begin
            state_next  = DONE;
            loaded_next = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_WIDTH'(1);
          end
        end
        // Abort wins over a coincident final beat: the load is incomplete.
        if (!stage_match) begin
          state_next  = IDLE;
          loaded_next = 1'b0;
        end
      end
      DONE: begin
        if (!stage_match) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One register pair per link; a slot only changes on a handshake addressed to it.
  for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_slot
    logic [LINK_BIT_WIDTH-1:0] weight_slot_reg;
    logic [1:0]                boundary_slot_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        weight_slot_reg   <= '0;
        boundary_slot_reg <= '0;
      end else if (accept && (idx_reg == IDX_WIDTH'(gi))) begin
        weight_slot_reg   <= wr_weight;
        boundary_slot_reg <= wr_boundary;
      end
    end

    assign weight_bus[gi*LINK_BIT_WIDTH +: LINK_BIT_WIDTH] = weight_slot_reg;
    assign boundary_bus[gi*2 +: 2]                         = boundary_slot_reg;
  end

`ifdef LINK_LOADER_PARAM_CHECK_EN
  localparam logic [LINK_BIT_WIDTH-1:0] MAX_WEIGHT_CODE = LINK_BIT_WIDTH'(MAX_WEIGHT);

  logic weight_over;
  logic boundary_fifo;
  logic error_reg;

  assign weight_over   = (param_weight > MAX_WEIGHT_CODE);
  assign boundary_fifo = (param_boundary == 2'd3);
  // Illegal entries are clamped to the nearest legal value rather than dropped.
  assign wr_weight     = weight_over ? MAX_WEIGHT_CODE : param_weight;
  assign wr_boundary   = boundary_fifo ? 2'd2 : param_boundary;
  assign param_error   = error_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      error_reg <= 1'b0;
    end else if (load_entry) begin
      error_reg <= 1'b0;
    end else if (accept && (weight_over || boundary_fifo)) begin
      error_reg <= 1'b1;
    end
  end
`else
  assign wr_weight   = param_weight;
  assign wr_boundary = param_boundary;
  assign param_error = 1'b0;
`endif

endmodule
